pairing_result_streamer: RTL and testbench

// - Downstream readout stage for the BN254 pairing core's result memory.
// - On start, it walks the result addresses 0..N_WORDS-1 on the core's extout_addr/extout_data port.
// - Each captured word is serialized into OUT_W-bit beats on a valid/ready stream toward the host link.
// - Replaces the external addr/LATCH pin polling with a self-timed, back-pressured transfer.

---
 rtl/pairing_result_streamer.sv | 157 +++++++++++++++
 tb/tb_pairing_result_streamer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pairing_result_streamer.sv
// Reads N_WORDS result words from the pairing core and streams them as OUT_W-bit beats (LSB beat first).
// Optional CRC-32 trailer beat when RESULT_STREAM_CRC_EN is defined.
module pairing_result_streamer #(
    parameter int WORD_W  = 512,
    parameter int OUT_W   = 32,
    parameter int N_WORDS = 12,
    parameter int ADDR_W  = 8,
    parameter int RD_LAT  = 2
) (
    input  logic              clk,
    input  logic              CPU_RESET,
    input  logic              start,
    output logic [ADDR_W-1:0] extout_addr,
    input  logic [WORD_W-1:0] extout_data,
    output logic [OUT_W-1:0]  m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);
    localparam int BEATS = WORD_W / OUT_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [BW-1:0]     LAST_BEAT = BW'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N_WORDS - 1);

    if (WORD_W % OUT_W != 0) begin : g_bad_width
        $error("WORD_W must be a multiple of OUT_W");
    end
    if (RD_LAT < 1) begin : g_bad_lat
        $error("RD_LAT must be at least 1");
    end
    if (N_WORDS < 1 || N_WORDS > 2**ADDR_W) begin : g_bad_words
        $error("N_WORDS must be in 1..2**ADDR_W");
    end

`ifdef RESULT_STREAM_CRC_EN
    if (OUT_W != 32) begin : g_bad_crc_width
        $error("CRC trailer requires OUT_W == 32");
    end

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_SHIFT, S_CRC, S_FIN} state_t;

    logic [31:0] crc;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c;
        for (int unsigned i = 0; i < 32; i++) begin
            if (r[31] ^ d[31 - i]) r = {r[30:0], 1'b0} ^ 32'h04C1_1DB7;
            else                   r = {r[30:0], 1'b0};
        end
        return r;
    endfunction
`else
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_SHIFT, S_FIN} state_t;
`endif

    state_t            state, state_nxt;
    logic [LW-1:0]     wait_cnt;
    logic [BW-1:0]     beat_idx;
    logic [WORD_W-1:0] shreg;
    logic              word_end, last_word;

    assign word_end  = (beat_idx == LAST_BEAT);
    assign last_word = (extout_addr == LAST_WORD);

    always_ff @(posedge clk) begin
        if (CPU_RESET) state <= S_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        m_data    = '0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_ADDR;
            end
            S_ADDR: state_nxt = S_WAIT;
            S_WAIT: if (wait_cnt == '0) state_nxt = S_SHIFT;
            S_SHIFT: begin
                m_valid = 1'b1;
                m_data  = shreg[OUT_W-1:0];
`ifdef RESULT_STREAM_CRC_EN
                if (m_ready && word_end) state_nxt = last_word ? S_CRC : S_ADDR;
`else
                m_last = word_end && last_word;
                if (m_ready && word_end) state_nxt = last_word ? S_FIN : S_ADDR;
`endif
            end
`ifdef RESULT_STREAM_CRC_EN
            S_CRC: begin
                m_valid = 1'b1;
                m_last  = 1'b1;
                m_data  = ~crc;
                if (m_ready) state_nxt = S_FIN;
            end
`endif
            S_FIN: begin
                busy      = 1'b0;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // extout_addr doubles as the word index, so it stays put from ADDR through capture
    always_ff @(posedge clk) begin
        if (CPU_RESET) begin
            extout_addr <= '0;
            wait_cnt    <= '0;
            beat_idx    <= '0;
            shreg       <= '0;
`ifdef RESULT_STREAM_CRC_EN
            crc         <= '1;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        extout_addr <= '0;
`ifdef RESULT_STREAM_CRC_EN
                        crc         <= '1;
`endif
                    end
                end
                S_ADDR: begin
                    wait_cnt <= LW'(RD_LAT - 1);
                    beat_idx <= '0;
                end
                S_WAIT: begin
                    if (wait_cnt == '0) shreg    <= extout_data;
                    else                wait_cnt <= wait_cnt - 1'b1;
                end
                S_SHIFT: begin
                    if (m_ready) begin
                        shreg    <= shreg >> OUT_W;
                        beat_idx <= beat_idx + 1'b1;
`ifdef RESULT_STREAM_CRC_EN
                        crc      <= crc_next(crc, shreg[OUT_W-1:0]);
`endif
                        if (word_end && !last_word) extout_addr <= extout_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pairing_result_streamer.sv
// Scoreboard bench for pairing_result_streamer: default instance plus an N_WORDS=1, RD_LAT=1 instance.
`timescale 1ns/1ps
module tb_pairing_result_streamer;
    localparam int WORD_W  = 512;
    localparam int OUT_W   = 32;
    localparam int BEATS   = 16;
    localparam int N_WORDS = 12;
    localparam int RD_LAT  = 2;
`ifdef RESULT_STREAM_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif
    localparam int TOTAL = N_WORDS * BEATS + (CRC_ON ? 1 : 0);

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst, start, m_ready;
    logic [7:0]        addr;
    logic [WORD_W-1:0] xdata;
    logic [OUT_W-1:0]  m_data;
    logic              m_valid, m_last, busy, done;

    logic              s_start;
    logic              s_ready = 1'b1;
    logic [7:0]        s_addr;
    logic [WORD_W-1:0] s_xdata;
    logic [OUT_W-1:0]  s_data;
    logic              s_valid, s_last, s_busy, s_done;

    int    pattern = 0;
    int    checks = 0, errors = 0;
    int    acc_cnt = 0, done_cnt = 0, s_acc_cnt = 0, s_done_cnt = 0;
    beat_t exp_q[$];
    beat_t s_q[$];

    always #5 clk = ~clk;

    pairing_result_streamer u_dut (
        .clk(clk), .CPU_RESET(rst), .start(start), .extout_addr(addr), .extout_data(xdata),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .done(done)
    );

    pairing_result_streamer #(.WORD_W(WORD_W), .OUT_W(OUT_W), .N_WORDS(1), .ADDR_W(8), .RD_LAT(1)) u_small (
        .clk(clk), .CPU_RESET(rst), .start(s_start), .extout_addr(s_addr), .extout_data(s_xdata),
        .m_data(s_data), .m_valid(s_valid), .m_last(s_last), .m_ready(s_ready),
        .busy(s_busy), .done(s_done)
    );

    // Word content by address; pattern 2 makes every beat distinct
    function automatic logic [WORD_W-1:0] word_of(input int pat, input logic [7:0] a);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int b = 0; b < BEATS; b++) begin
            case (pat)
                0:       w[b*32 +: 32] = {a, 24'h0};
                2:       w[b*32 +: 32] = {a, 8'(b), 16'h5A00 ^ {8'h00, a[3:0], 4'(b)}};
                default: w[b*32 +: 32] = 32'h0;
            endcase
        end
        return w;
    endfunction

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
        logic fb;
        for (int i = 31; i >= 0; i--) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0};
            if (fb) c = c ^ 32'h04C11DB7;
        end
        return c;
    endfunction

    // Pairing-core read port model: RD_LAT register stages on the address
    logic [7:0] pipe [RD_LAT];
    logic [7:0] s_pipe;
    always @(posedge clk) begin
        pipe[0] <= addr;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        s_pipe <= s_addr;
    end
    assign xdata   = word_of(pattern, pipe[RD_LAT-1]);
    assign s_xdata = word_of(2, s_pipe);

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int pat, input int nw, input bit to_small);
        logic [31:0]       crc;
        logic [WORD_W-1:0] w;
        beat_t             e;
        crc = '1;
        for (int wi = 0; wi < nw; wi++) begin
            w = word_of(pat, 8'(wi));
            for (int b = 0; b < BEATS; b++) begin
                e.d = w[b*32 +: 32];
                e.l = !CRC_ON && (wi == nw - 1) && (b == BEATS - 1);
                crc = crc_step(crc, e.d);
                if (to_small) s_q.push_back(e);
                else          exp_q.push_back(e);
            end
        end
        if (CRC_ON) begin
            e.d = ~crc;
            e.l = 1'b1;
            if (to_small) s_q.push_back(e);
            else          exp_q.push_back(e);
        end
    endtask

    // Main monitor: pops on every accepted beat, checks hold-while-stalled
    bit    stall = 1'b0;
    beat_t held;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (stall) begin
                check("stall_valid", 64'(m_valid), 64'd1);
                check("stall_hold", 64'({m_data, m_last}), 64'(held));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(m_data), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 64'(m_data), 64'(e.d));
                    check("beat_last", 64'(m_last), 64'(e.l));
                end
                acc_cnt++;
                stall = 1'b0;
            end else if (m_valid) begin
                stall = 1'b1;
                held  = {m_data, m_last};
            end else begin
                stall = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            if (s_done) s_done_cnt++;
            if (s_busy) check("small_addr", 64'(s_addr), 64'd0);
            if (s_valid) begin
                if (s_q.size() == 0) begin
                    check("small_unexpected", 64'(s_data), 64'hDEAD);
                end else begin
                    e = s_q.pop_front();
                    check("small_data", 64'(s_data), 64'(e.d));
                    check("small_last", 64'(s_last), 64'(e.l));
                end
                s_acc_cnt++;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int limit);
        int n = 0;
        while (done_cnt == d0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == d0) check("done_timeout", 64'(n), 64'(0));
        repeat (4) @(posedge clk);
    endtask

    task automatic end_checks(input string nm, input int d0, input int a0);
        check({nm, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        check({nm, "_beats"}, 64'(acc_cnt - a0), 64'(TOTAL));
        check({nm, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        check({nm, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int d0, a0, lat, n;
        rst = 1'b1; start = 1'b0; s_start = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_data", 64'(m_data), 64'd0);
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_last", 64'(m_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Basic transfer with latency measurement
        pattern = 0; push_exp(0, N_WORDS, 1'b0); d0 = done_cnt; a0 = acc_cnt;
        @(posedge clk); #1 start = 1'b1;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); lat++; #1 start = 1'b0;
            if (lat == 1) check("busy_after_start", 64'(busy), 64'd1);
            @(negedge clk);
            if (m_valid) break;
        end
        check("first_valid_latency", 64'(lat), 64'd4);
        wait_done(d0, 2000);
        end_checks("basic", d0, a0);

        // Random backpressure
        pattern = 2; push_exp(2, N_WORDS, 1'b0); d0 = done_cnt; a0 = acc_cnt;
        pulse_start();
        n = 0;
        while (done_cnt == d0 && n < 4000) begin
            @(posedge clk); #1 m_ready = 1'($urandom_range(0, 1)); n++;
        end
        m_ready = 1'b1;
        wait_done(d0, 10);
        end_checks("backpressure", d0, a0);

        // Second start while busy is ignored
        pattern = 0; push_exp(0, N_WORDS, 1'b0); d0 = done_cnt; a0 = acc_cnt;
        pulse_start();
        n = 0;
        while (acc_cnt - a0 < 10 && n < 200) begin @(posedge clk); n++; end
        pulse_start();
        wait_done(d0, 2000);
        repeat (20) @(posedge clk);
        end_checks("start_ignored", d0, a0);

        // Reset mid-transfer, then a clean full transfer
        pattern = 2; push_exp(2, N_WORDS, 1'b0); d0 = done_cnt;
        pulse_start();
        a0 = acc_cnt; n = 0;
        while (acc_cnt - a0 < 50 && n < 500) begin @(posedge clk); n++; end
        #1 rst = 1'b1; m_ready = 1'b0;
        @(posedge clk); #1;
        check("midrst_addr", 64'(addr), 64'd0);
        check("midrst_data", 64'(m_data), 64'd0);
        check("midrst_valid", 64'(m_valid), 64'd0);
        check("midrst_last", 64'(m_last), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        rst = 1'b0; m_ready = 1'b1; exp_q.delete();
        repeat (10) @(posedge clk);
        check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        push_exp(2, N_WORDS, 1'b0); d0 = done_cnt; a0 = acc_cnt;
        pulse_start();
        wait_done(d0, 2000);
        end_checks("after_reset", d0, a0);

        // All-zero data (CRC trailer when enabled)
        pattern = 1; push_exp(1, N_WORDS, 1'b0); d0 = done_cnt; a0 = acc_cnt;
        pulse_start();
        wait_done(d0, 2000);
        end_checks("zero_data", d0, a0);

        // Single-word, RD_LAT=1 instance
        push_exp(2, 1, 1'b1); d0 = s_done_cnt; a0 = s_acc_cnt;
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        n = 0;
        while (s_done_cnt == d0 && n < 200) begin @(posedge clk); n++; end
        repeat (4) @(posedge clk);
        check("small_done_count", 64'(s_done_cnt - d0), 64'd1);
        check("small_beats", 64'(s_acc_cnt - a0), 64'(BEATS + (CRC_ON ? 1 : 0)));
        check("small_queue_empty", 64'(s_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors + 1);
        $fatal(1, "watchdog");
    end
endmodule
